// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared types and constants for the AXI4-lite requester arbiter.
// Combinational only; no latency or backpressure of its own.
package axi4_lite_pkg;

  localparam int AXI_RESP_W = 3;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 3'd0;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_XFER,
    WR_RESP
  } arb_state_e;

endpackage

// File: rtl/axi4_lite_arbiter_if.sv
// Upstream multi-requester bundle and single downstream AXI4-lite port.
// Pure wiring; handshakes are plain valid/ready with no added latency.
interface axi4_lite_up_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  import axi4_lite_pkg::*;

  logic [NUM_REQ-1:0]                 arvalid, arready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] araddr;
  logic [NUM_REQ-1:0]                 rvalid, rready;
  logic [DATA_WIDTH-1:0]              rdata;
  logic [NUM_REQ-1:0]                 awvalid, awready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] awaddr;
  logic [NUM_REQ-1:0]                 wvalid, wready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]                 bvalid, bready;
  logic [AXI_RESP_W-1:0]              bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
    input  arready, rvalid, rdata, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
    output arready, rvalid, rdata, awready, wready, bvalid, bresp
  );
endinterface

interface axi4_lite_dn_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  import axi4_lite_pkg::*;

  logic                  arvalid, arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid, rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  awvalid, awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid, wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  bvalid, bready;
  logic [AXI_RESP_W-1:0] bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
    input  arready, rvalid, rdata, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
    output arready, rvalid, rdata, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi4_lite_arbiter_rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, wrapping at N-1.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // One spare bit so ptr+k never overflows before the explicit wrap.
  localparam int CW = IW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!gnt_vld && req[cand[IW-1:0]]) begin
        gnt_vld                = 1'b1;
        gnt_idx                = cand[IW-1:0];
        gnt_oh[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Serialises NUM_REQ AXI4-lite requesters onto one subordinate, one transaction at a time.
// One arbitration bubble then combinational pass-through; backpressure flows straight through.
module axi4_lite_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           aclk,
  input  logic           areset,
  axi4_lite_up_if.slave  up,
  axi4_lite_dn_if.master dn
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         ptr_q, ptr_d, ptr_next;
  logic [NUM_REQ-1:0]    rw_last_q, rw_last_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic [NUM_REQ-1:0]    req, gnt_oh;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic                  pick_wr;
  logic                  aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] araddr_sel, awaddr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  assign req = up.arvalid | up.awvalid;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // rw_last bit set means the previous grant to that requester was a write.
  assign pick_wr = (|(gnt_oh & up.awvalid)) &
                   (~(|(gnt_oh & up.arvalid)) | ~(|(gnt_oh & rw_last_q)));

  assign ptr_next   = (grant_q == LAST) ? '0 : grant_q + IW'(1);
  assign araddr_sel = up.araddr[grant_q];
  assign awaddr_sel = up.awaddr[grant_q];
  assign wdata_sel  = up.wdata[grant_q];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      rw_last_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      rw_last_q <= rw_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    rw_last_d  = rw_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;

    up.arready = '0;
    up.rvalid  = '0;
    up.rdata   = '0;
    up.awready = '0;
    up.wready  = '0;
    up.bvalid  = '0;
    up.bresp   = '0;
    dn.arvalid = 1'b0;
    dn.araddr  = '0;
    dn.rready  = 1'b0;
    dn.awvalid = 1'b0;
    dn.awaddr  = '0;
    dn.wvalid  = 1'b0;
    dn.wdata   = '0;
    dn.bready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant_d            = gnt_idx;
          rw_last_d[gnt_idx] = pick_wr;
          state_d            = pick_wr ? WR_XFER : RD_ADDR;
        end
      end
      RD_ADDR: begin
        dn.arvalid          = up.arvalid[grant_q];
        dn.araddr           = araddr_sel;
        up.arready[grant_q] = dn.arready;
        if (up.arvalid[grant_q] && dn.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        up.rvalid[grant_q] = dn.rvalid;
        up.rdata           = dn.rdata;
        dn.rready          = up.rready[grant_q];
        if (dn.rvalid && up.rready[grant_q]) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      WR_XFER: begin
        // Each channel goes quiet once its own handshake has completed.
        dn.awvalid          = up.awvalid[grant_q] & ~aw_done_q;
        dn.awaddr           = awaddr_sel;
        up.awready[grant_q] = dn.awready & ~aw_done_q;
        dn.wvalid           = up.wvalid[grant_q] & ~w_done_q;
        dn.wdata            = wdata_sel;
        up.wready[grant_q]  = dn.wready & ~w_done_q;
        aw_hs = up.awvalid[grant_q] & ~aw_done_q & dn.awready;
        w_hs  = up.wvalid[grant_q] & ~w_done_q & dn.wready;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WR_RESP: begin
        up.bvalid[grant_q] = dn.bvalid;
        up.bresp           = dn.bresp;
        dn.bready          = up.bready[grant_q];
        if (dn.bvalid && up.bready[grant_q]) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed cycle-by-cycle vectors for the AXI4-lite arbiter, plus a reset-abort sequence.
module tb_axi4_lite_arbiter;
  import axi4_lite_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  axi4_lite_up_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up ();
  axi4_lite_dn_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();

  axi4_lite_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .up     (up),
    .dn     (dn)
  );

  // upi = {arvalid, awvalid, wvalid, rready, bready} (2 bits each)
  // dni = {arready, rvalid, awready, wready, bvalid}
  // ex  = {up arready, rvalid, awready, wready, bvalid (2 each), dn arvalid, rready, awvalid, wvalid, bready}
  typedef struct {
    int          tid;
    int          g;
    logic [9:0]  upi;
    logic [4:0]  dni;
    logic [31:0] rdata;
    logic [2:0]  bresp;
    logic [14:0] ex;
  } vec_t;

  vec_t        vt[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] araddr_tbl [2];
  logic [31:0] awaddr_tbl [2];
  logic [31:0] wdata_tbl  [2];

  task automatic add(input int tid, input int g, input logic [9:0] upi, input logic [4:0] dni,
                     input logic [31:0] rd, input logic [2:0] br, input logic [14:0] ex);
    vec_t v;
    v.tid = tid; v.g = g; v.upi = upi; v.dni = dni; v.rdata = rd; v.bresp = br; v.ex = ex;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] hs_now();
    return {up.arready, up.rvalid, up.awready, up.wready, up.bvalid,
            dn.arvalid, dn.rready, dn.awvalid, dn.wvalid, dn.bready};
  endfunction

  task automatic drive(input logic [9:0] upi, input logic [4:0] dni,
                       input logic [31:0] rd, input logic [2:0] br);
    {up.arvalid, up.awvalid, up.wvalid, up.rready, up.bready} = upi;
    {dn.arready, dn.rvalid, dn.awready, dn.wready, dn.bvalid} = dni;
    dn.rdata = rd;
    dn.bresp = br;
  endtask

  initial begin
    logic [1:0] sel;
    araddr_tbl[0] = 32'h0000_0100; araddr_tbl[1] = 32'h0000_0180;
    awaddr_tbl[0] = 32'h0000_0300; awaddr_tbl[1] = 32'h0000_0200;
    wdata_tbl[0]  = 32'h0000_00A5; wdata_tbl[1]  = 32'h0000_0055;
    for (int k = 0; k < NR; k++) begin
      up.araddr[k] = araddr_tbl[k];
      up.awaddr[k] = awaddr_tbl[k];
      up.wdata[k]  = wdata_tbl[k];
    end
    drive(10'b11_11_11_11_11, 5'b1_1_1_1_1, 32'hFFFF_FFFF, RESP_SLVERR);

    // Reset state: everything quiet even with all inputs active.
    #1 areset = 1'b1;
    #2;
    chk("reset handshakes", 32'(hs_now()), 32'h0);
    chk("reset up_rdata", up.rdata, 32'h0);
    chk("reset up_bresp", 32'(up.bresp), 32'h0);
    chk("reset state", 32'(dut.state_q), 32'(IDLE));
    @(negedge aclk);
    drive(10'b0, 5'b1_0_1_1_0, 32'h0, 3'd0);
    areset = 1'b0;

    // Single read from requester 0.
    add(2, 0, 10'b01_00_00_01_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(2, 0, 10'b01_00_00_01_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b01_00_00_00_00_10000);
    add(2, 0, 10'b00_00_00_01_00, 5'b1_1_1_1_0, 32'hDEAD_BEEF, 3'd0, 15'b00_01_00_00_00_01000);
    add(2, 0, 10'b00_00_00_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);

    // Split write from requester 1: W leads AW, AW stalls once downstream.
    add(4, 1, 10'b00_00_10_00_10, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(4, 1, 10'b00_00_10_00_10, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(4, 1, 10'b00_10_10_00_10, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(4, 1, 10'b00_10_10_00_10, 5'b1_0_0_1_0, 32'h0, 3'd0, 15'b00_00_00_10_00_00110);
    add(4, 1, 10'b00_10_10_00_10, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_10_00_00_00100);
    add(4, 1, 10'b00_00_00_00_10, 5'b1_0_1_1_1, 32'h0, RESP_OKAY, 15'b00_00_00_00_10_00001);
    add(4, 1, 10'b00_00_00_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);

    // Both requesters reading continuously: grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      sel = 2'b01 << (k % 2);
      add(3, k % 2, 10'b11_00_00_11_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b0);
      add(3, k % 2, 10'b11_00_00_11_00, 5'b1_0_1_1_0, 32'h0, 3'd0, {sel, 8'b0, 5'b10000});
      add(3, k % 2, 10'b11_00_00_11_00, 5'b1_1_1_1_0, 32'hC0DE_0000 + k, 3'd0,
          {2'b00, sel, 6'b0, 5'b01000});
    end

    // Write from requester 0 with response held off 5 cycles; requester 1 gives up before grant.
    add(6, 0, 10'b00_01_01_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(6, 0, 10'b00_01_01_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_01_01_00_00110);
    for (int k = 0; k < 5; k++)
      add(6, 0, 10'b10_00_00_00_00, 5'b1_0_1_1_1, 32'h0, RESP_SLVERR, 15'b00_00_00_00_01_00000);
    add(6, 0, 10'b10_00_00_00_01, 5'b1_0_1_1_1, 32'h0, RESP_SLVERR, 15'b00_00_00_00_01_00001);
    add(6, 0, 10'b00_00_00_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);
    add(6, 0, 10'b00_00_00_00_00, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_00_00_00_00000);

    // Requester 0 holds read and write; last was a write, so R,W,R,W.
    for (int k = 0; k < 4; k++) begin
      add(5, 0, 10'b01_01_01_01_01, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b0);
      if (k % 2 == 0) begin
        add(5, 0, 10'b01_01_01_01_01, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b01_00_00_00_00_10000);
        add(5, 0, 10'b01_01_01_01_01, 5'b1_1_1_1_0, 32'hA000_0000 + k, 3'd0,
            15'b00_01_00_00_00_01000);
      end else begin
        add(5, 0, 10'b01_01_01_01_01, 5'b1_0_1_1_0, 32'h0, 3'd0, 15'b00_00_01_01_00_00110);
        add(5, 0, 10'b01_01_01_01_01, 5'b1_0_1_1_1, 32'h0, RESP_OKAY, 15'b00_00_00_00_01_00001);
      end
    end

    foreach (vt[i]) begin
      @(negedge aclk);
      drive(vt[i].upi, vt[i].dni, vt[i].rdata, vt[i].bresp);
      #1;
      chk($sformatf("v%0d/t%0d handshakes", i, vt[i].tid), 32'(hs_now()), 32'(vt[i].ex));
      if (vt[i].ex[4])
        chk($sformatf("v%0d/t%0d dn_araddr", i, vt[i].tid), dn.araddr, araddr_tbl[vt[i].g]);
      if (vt[i].ex[2])
        chk($sformatf("v%0d/t%0d dn_awaddr", i, vt[i].tid), dn.awaddr, awaddr_tbl[vt[i].g]);
      if (vt[i].ex[1])
        chk($sformatf("v%0d/t%0d dn_wdata", i, vt[i].tid), dn.wdata, wdata_tbl[vt[i].g]);
      if (|vt[i].ex[12:11])
        chk($sformatf("v%0d/t%0d up_rdata", i, vt[i].tid), up.rdata, vt[i].rdata);
      if (|vt[i].ex[6:5])
        chk($sformatf("v%0d/t%0d up_bresp", i, vt[i].tid), 32'(up.bresp), 32'(vt[i].bresp));
    end

    // Reset during RD_DATA of requester 1 (pointer is 1 here).
    @(negedge aclk);
    drive(10'b10_00_00_10_00, 5'b1_0_1_1_0, 32'h0, 3'd0);
    @(negedge aclk);
    @(negedge aclk);
    drive(10'b00_00_00_10_00, 5'b1_1_1_1_0, 32'h1234_5678, 3'd0);
    #1;
    chk("abort pre-reset rvalid", 32'(hs_now()), 32'(15'b00_10_00_00_00_01000));
    areset = 1'b1;
    #1;
    chk("abort handshakes", 32'(hs_now()), 32'h0);
    chk("abort up_rdata", up.rdata, 32'h0);
    @(negedge aclk);
    drive(10'b11_00_00_11_00, 5'b1_0_1_1_0, 32'h0, 3'd0);
    areset = 1'b0;
    #1;
    chk("abort state", 32'(dut.state_q), 32'(IDLE));
    chk("abort pointer", 32'(dut.ptr_q), 32'h0);
    @(negedge aclk);
    #1;
    chk("abort first grant", 32'(hs_now()), 32'(15'b01_00_00_00_00_10000));
    chk("abort araddr", dn.araddr, araddr_tbl[0]);
    drive(10'b00_00_00_11_00, 5'b1_0_1_1_0, 32'h0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
